// File: rtl/clock_pkg.sv
// Shared definitions for the time_keeper slice.
// Contents: keypad command codes, FSM state enum, BCD digit limits,
// nibble offsets inside a {Ht, Hu, Mt, Mu} time word, and a helper that
// checks whether a time word is a legal 24-hour HH:MM value.
package clock_pkg;

  localparam logic [3:0] KEY_ALARM = 4'hA;
  localparam logic [3:0] KEY_TIME  = 4'hB;

  // Largest legal value for each BCD position.
  localparam logic [3:0] BCD_MAX_HT      = 4'd2;
  localparam logic [3:0] BCD_MAX_HU_AT_2 = 4'd3;  // hour units when Ht = 2
  localparam logic [3:0] BCD_MAX_MT      = 4'd5;
  localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;

  // Nibble offsets within a time word.
  localparam int HT_LSB = 12;
  localparam int HU_LSB = 8;
  localparam int MT_LSB = 4;
  localparam int MU_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ENTRY      = 2'd1,
    ST_LOAD_ALARM = 2'd2,
    ST_LOAD_TIME  = 2'd3
  } tk_state_t;

  function automatic logic time_valid(input logic [15:0] w);
    logic [3:0] ht, hu, mt, mu;
    ht = w[HT_LSB +: 4];
    hu = w[HU_LSB +: 4];
    mt = w[MT_LSB +: 4];
    mu = w[MU_LSB +: 4];
    time_valid = (ht <= BCD_MAX_HT) && (hu <= BCD_MAX_DIGIT) &&
                 (mt <= BCD_MAX_MT) && (mu <= BCD_MAX_DIGIT) &&
                 !((ht == BCD_MAX_HT) && (hu > BCD_MAX_HU_AT_2));
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Keypad handshake bundle.
// A key transfers on a rising clock edge where key_valid && key_ready.
// The source may present or change key freely; the sink never stalls on
// key_valid and only lowers key_ready while it commits an entry.
//   key_valid : source has a key this cycle
//   key       : key code (0-9 digit, A = ALARM, B = TIME, C-F discarded)
//   key_ready : sink can take a key this cycle
interface time_keeper_if;
  logic       key_valid;
  logic [3:0] key;
  logic       key_ready;

  modport master (output key_valid, output key, input key_ready);
  modport slave  (input key_valid, input key, output key_ready);
endinterface

// File: rtl/bcd_time_counter.sv
// 24-hour BCD HH:MM counter holding current_time.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc         : advance one minute
//   load        : overwrite with load_value (wins over inc)
//   load_value  : BCD {Ht, Hu, Mt, Mu}
//   time_out    : registered counter value
module bcd_time_counter
  import clock_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] time_out
);

  logic [15:0] time_q, time_d;
  logic [3:0]  ht, hu, mt, mu;

  assign ht = time_q[HT_LSB +: 4];
  assign hu = time_q[HU_LSB +: 4];
  assign mt = time_q[MT_LSB +: 4];
  assign mu = time_q[MU_LSB +: 4];

  always_comb begin
    time_d = time_q;
    if (load) begin
      time_d = load_value;
    end else if (inc) begin
      if (mu != BCD_MAX_DIGIT) begin
        time_d[MU_LSB +: 4] = mu + 4'd1;
      end else begin
        time_d[MU_LSB +: 4] = 4'd0;
        if (mt != BCD_MAX_MT) begin
          time_d[MT_LSB +: 4] = mt + 4'd1;
        end else begin
          time_d[MT_LSB +: 4] = 4'd0;
          // Hour carry: 23 wraps to 00, x9 carries into the tens digit.
          if ((ht == BCD_MAX_HT) && (hu == BCD_MAX_HU_AT_2)) begin
            time_d[HT_LSB +: 4] = 4'd0;
            time_d[HU_LSB +: 4] = 4'd0;
          end else if (hu == BCD_MAX_DIGIT) begin
            time_d[HT_LSB +: 4] = ht + 4'd1;
            time_d[HU_LSB +: 4] = 4'd0;
          end else begin
            time_d[HU_LSB +: 4] = hu + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) time_q <= 16'h0000;
    else        time_q <= time_d;
  end

  assign time_out = time_q;

endmodule

// File: rtl/time_keeper.sv
// Keeps current_time (minute-ticked) and alarm_time, both rewritable
// through a four-digit keypad entry buffer committed by ALARM/TIME keys.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   one_minute    : one-cycle pulse advancing current_time
//   timeout_tick  : one-cycle pulse driving the entry-abandon timeout
//   kbd           : keypad handshake (slave side)
//   current_time  : BCD HH:MM clock
//   alarm_time    : BCD HH:MM alarm setting
//   entry_time    : entry buffer being typed
//   show_entry    : entry in progress (ENTRY or LOAD state)
//   entry_error   : one-cycle pulse on a rejected commit
//   dbg_state     : FSM state register
module time_keeper
  import clock_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             one_minute,
  input  logic             timeout_tick,
  time_keeper_if.slave     kbd,
  output logic [15:0]      current_time,
  output logic [15:0]      alarm_time,
  output logic [15:0]      entry_time,
  output logic             show_entry,
  output logic             entry_error,
  output tk_state_t        dbg_state
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  tk_state_t   state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [15:0] alarm_q, alarm_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        load_time;
  logic        key_acc, is_digit, tmo_last;

  assign kbd.key_ready = (state_q == ST_IDLE) || (state_q == ST_ENTRY);
  assign show_entry    = (state_q != ST_IDLE);
  assign key_acc       = kbd.key_valid && kbd.key_ready;
  assign is_digit      = (kbd.key <= BCD_MAX_DIGIT);
  // This tick is the one that brings the count to TIMEOUT_TICKS.
  assign tmo_last      = (({1'b0, tmo_q} + 1'b1) == (TW+1)'(TIMEOUT_TICKS));

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    alarm_d   = alarm_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    load_time = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (key_acc && is_digit) begin
          entry_d = {12'h000, kbd.key};
          tmo_d   = '0;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        // An accepted key always beats a coincident timeout_tick.
        if (key_acc) begin
          tmo_d = '0;
          if (is_digit) begin
            entry_d = {entry_q[11:0], kbd.key};
          end else if ((kbd.key == KEY_ALARM) || (kbd.key == KEY_TIME)) begin
            if (time_valid(entry_q)) begin
              state_d = (kbd.key == KEY_ALARM) ? ST_LOAD_ALARM : ST_LOAD_TIME;
            end else begin
              err_d   = 1'b1;
              entry_d = 16'h0000;
              state_d = ST_IDLE;
            end
          end
        end else if (timeout_tick) begin
          if (tmo_last) begin
            tmo_d   = '0;
            entry_d = 16'h0000;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      ST_LOAD_ALARM: begin
        alarm_d = entry_q;
        entry_d = 16'h0000;
        state_d = ST_IDLE;
      end
      ST_LOAD_TIME: begin
        load_time = 1'b1;
        entry_d   = 16'h0000;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      entry_q <= 16'h0000;
      alarm_q <= 16'h0000;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      alarm_q <= alarm_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // A load in the same cycle as one_minute drops that minute.
  bcd_time_counter u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (one_minute),
    .load       (load_time),
    .load_value (entry_q),
    .time_out   (current_time)
  );

  assign alarm_time  = alarm_q;
  assign entry_time  = entry_q;
  assign entry_error = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;
  import clock_pkg::*;

  localparam int TMO = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        one_minute = 1'b0;
  logic        timeout_tick = 1'b0;
  logic [15:0] current_time, alarm_time, entry_time;
  logic        show_entry, entry_error;
  tk_state_t   dbg_state;

  time_keeper_if kif();

  time_keeper #(.TIMEOUT_TICKS(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .one_minute   (one_minute),
    .timeout_tick (timeout_tick),
    .kbd          (kif),
    .current_time (current_time),
    .alarm_time   (alarm_time),
    .entry_time   (entry_time),
    .show_entry   (show_entry),
    .entry_error  (entry_error),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [15:0] model_time;   // reference current_time
  logic [15:0] model_alarm;  // reference alarm_time

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // Reference minute increment via minutes-since-midnight arithmetic.
  function automatic logic [15:0] next_minute(input logic [15:0] w);
    int m, h, mi;
    m  = (int'(w[15:12]) * 10 + int'(w[11:8])) * 60 + int'(w[7:4]) * 10 + int'(w[3:0]);
    m  = (m + 1) % 1440;
    h  = m / 60;
    mi = m % 60;
    next_minute = {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
  endfunction

  // ---------------- driver tasks ----------------
  // Every task starts and ends at a falling edge; outputs sampled there.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key       = k;
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] w);
    press(w[15:12]);
    press(w[11:8]);
    press(w[7:4]);
    press(w[3:0]);
  endtask

  task automatic minute();
    model_time = next_minute(model_time);
    exp_q.push_back(model_time);
    @(negedge clk);
    one_minute = 1'b1;
    @(negedge clk);
    one_minute = 1'b0;
    chk_pop("minute_step", current_time);
  endtask

  task automatic tick();
    @(negedge clk);
    timeout_tick = 1'b1;
    @(negedge clk);
    timeout_tick = 1'b0;
  endtask

  task automatic set_time(input logic [15:0] w);
    enter4(w);
    model_time = w;
    exp_q.push_back(w);
    press(KEY_TIME);
    chk("load_time_ready_low", {15'd0, kif.key_ready}, 16'd0);
    @(negedge clk);
    chk_pop("set_time", current_time);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    kif.key_valid = 1'b0;
    kif.key       = 4'h0;
    model_time    = 16'h0000;
    model_alarm   = 16'h0000;

    // Reset values
    #12;
    chk("rst_current", current_time, 16'h0000);
    chk("rst_alarm", alarm_time, 16'h0000);
    chk("rst_entry", entry_time, 16'h0000);
    chk("rst_show", {15'd0, show_entry}, 16'd0);
    chk("rst_err", {15'd0, entry_error}, 16'd0);
    chk("rst_ready", {15'd0, kif.key_ready}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 60 minutes: 0000 -> 0100
    for (int i = 0; i < 60; i++) minute();
    chk("sixty_minutes", current_time, 16'h0100);

    // Rollover 2359 -> 0000 and 0959 -> 1000
    set_time(16'h2359);
    minute();
    chk("roll_2359", current_time, 16'h0000);
    set_time(16'h0959);
    minute();
    chk("roll_0959", current_time, 16'h1000);

    // ALARM commit 1230 with two-edge latency
    enter4(16'h1230);
    chk("entry_echo", entry_time, 16'h1230);
    chk("entry_show", {15'd0, show_entry}, 16'd1);
    model_alarm = 16'h1230;
    exp_q.push_back(model_alarm);
    press(KEY_ALARM);
    chk("alarm_ready_low", {15'd0, kif.key_ready}, 16'd0);
    chk("alarm_state", {14'd0, dbg_state}, {14'd0, ST_LOAD_ALARM});
    chk("alarm_not_yet", alarm_time, 16'h0000);
    @(negedge clk);
    chk_pop("alarm_set", alarm_time);
    chk("alarm_ready_back", {15'd0, kif.key_ready}, 16'd1);
    chk("alarm_cur_same", current_time, model_time);
    chk("alarm_entry_clr", entry_time, 16'h0000);

    // Five digits: oldest shifted out
    press(4'h9);
    enter4(16'h1234);
    chk("five_digit_buf", entry_time, 16'h1234);
    model_time = 16'h1234;
    exp_q.push_back(model_time);
    press(KEY_TIME);
    @(negedge clk);
    chk_pop("five_digit_time", current_time);

    // Invalid: 2400
    enter4(16'h2400);
    press(KEY_TIME);
    chk("err_2400_pulse", {15'd0, entry_error}, 16'd1);
    chk("err_2400_idle", {14'd0, dbg_state}, {14'd0, ST_IDLE});
    chk("err_2400_clr", entry_time, 16'h0000);
    @(negedge clk);
    chk("err_2400_once", {15'd0, entry_error}, 16'd0);
    chk("err_2400_cur", current_time, model_time);

    // Invalid: 1260 (Mt = 6)
    enter4(16'h1260);
    press(KEY_ALARM);
    chk("err_1260_pulse", {15'd0, entry_error}, 16'd1);
    @(negedge clk);
    chk("err_1260_once", {15'd0, entry_error}, 16'd0);
    chk("err_1260_alarm", alarm_time, model_alarm);
    chk("err_1260_cur", current_time, model_time);

    // Timeout: 1,2 then TMO ticks
    press(4'h1);
    press(4'h2);
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("tmo_before", {15'd0, show_entry}, 16'd1);
    tick();
    chk("tmo_show", {15'd0, show_entry}, 16'd0);
    chk("tmo_entry", entry_time, 16'h0000);
    chk("tmo_no_err", {15'd0, entry_error}, 16'd0);
    chk("tmo_cur", current_time, model_time);
    chk("tmo_alarm", alarm_time, model_alarm);

    // ALARM key in IDLE does nothing
    press(KEY_ALARM);
    chk("idle_cmd_state", {14'd0, dbg_state}, {14'd0, ST_IDLE});
    @(negedge clk);
    chk("idle_cmd_alarm", alarm_time, model_alarm);

    // Key coinciding with timeout_tick clears the counter
    press(4'h1);
    for (int i = 0; i < TMO - 1; i++) tick();
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key       = 4'h2;
    timeout_tick  = 1'b1;
    @(negedge clk);
    kif.key_valid = 1'b0;
    timeout_tick  = 1'b0;
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("tmo_restart_show", {15'd0, show_entry}, 16'd1);
    chk("tmo_restart_buf", entry_time, 16'h0012);
    tick();
    chk("tmo_restart_end", {15'd0, show_entry}, 16'd0);

    // LOAD_TIME with one_minute: load wins, tick dropped
    enter4(16'h0815);
    model_time = 16'h0815;
    exp_q.push_back(model_time);
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key       = KEY_TIME;
    @(negedge clk);
    kif.key_valid = 1'b0;
    one_minute    = 1'b1;
    @(negedge clk);
    one_minute    = 1'b0;
    chk_pop("load_beats_minute", current_time);

    // LOAD_ALARM with one_minute: both happen
    enter4(16'h0600);
    model_alarm = 16'h0600;
    model_time  = next_minute(model_time);
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key       = KEY_ALARM;
    @(negedge clk);
    kif.key_valid = 1'b0;
    one_minute    = 1'b1;
    @(negedge clk);
    one_minute    = 1'b0;
    chk("alarm_and_min_a", alarm_time, model_alarm);
    chk("alarm_and_min_t", current_time, model_time);

    // Reset mid-entry
    press(4'h1);
    press(4'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_current", current_time, 16'h0000);
    chk("mid_rst_alarm", alarm_time, 16'h0000);
    chk("mid_rst_entry", entry_time, 16'h0000);
    chk("mid_rst_show", {15'd0, show_entry}, 16'd0);
    chk("mid_rst_err", {15'd0, entry_error}, 16'd0);
    chk("mid_rst_ready", {15'd0, kif.key_ready}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", {14'd0, dbg_state}, {14'd0, ST_IDLE});

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
